// File: rtl/seq_match_sched_if.sv
// Bus between the serial front-end channels, the match scheduler and the
// status logic. Parameters must agree with the seq_match_sched instance
// the bus is bound to.
//
// Handshake: a channel's bit is transferred in a cycle exactly when
// gnt[i] && bit_vld[i] at the rising clock edge. gnt acts as the ready
// for channel i and bit_vld[i] as its valid. A channel may present
// bit_vld without gnt; nothing is consumed then. req[i] is a level that
// must stay high for the whole granted frame. Dropping it ends the frame
// early, and the bit offered in that cycle is not consumed.
interface seq_match_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] bit_vld;
    logic [N_REQ-1:0] bit_dat;
    logic [N_REQ-1:0] gnt;
    logic             busy;
    logic             hit;
    logic             done;
    logic [ID_W-1:0]  done_id;
    logic [CNT_W-1:0] done_cnt;
    logic             done_abort;

    // Front-end / requester side.
    modport master (
        output req, bit_vld, bit_dat,
        input  gnt, busy, hit, done, done_id, done_cnt, done_abort
    );

    // Scheduler side.
    modport slave (
        input  req, bit_vld, bit_dat,
        output gnt, busy, hit, done, done_id, done_cnt, done_abort
    );
endinterface

// File: rtl/seq_match_sched.sv
// Round-robin scheduler that time-shares one serial "1101" matcher
// between N_REQ bit-stream requesters. Each granted frame runs FRAME_LEN
// consumed bits, or ends early on a request drop. The frame result is
// reported for one cycle.
module seq_match_sched #(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_match_sched_if.slave   bus,
    output logic [1:0]         dbg_state_o
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        E_S0 = 2'd0,
        E_S1 = 2'd1,
        E_S2 = 2'd2,
        E_S3 = 2'd3
    } eng_t;

    state_t           state_q;
    eng_t             eng_q;
    eng_t             eng_d;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  ptr_d;
    logic [ID_W-1:0]  g_q;
    logic [BC_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] hit_cnt_d;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] gnt_d;
    logic             busy_q;
    logic             hit_q;
    logic             done_q;
    logic [ID_W-1:0]  done_id_q;
    logic [CNT_W-1:0] done_cnt_q;
    logic             done_abort_q;

    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic             match;
    logic             cur_bit;
    logic             cur_vld;
    logic             cur_req;

    // The granted channel's own signals; only these reach the engine.
    assign cur_bit = bus.bit_dat[g_q];
    assign cur_vld = bus.bit_vld[g_q];
    assign cur_req = bus.req[g_q];

    // Round-robin search upward from ptr_q; the first active request wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && bus.req[(int'(ptr_q) + k) % N_REQ]) begin
                win_found = 1'b1;
                win_id    = ID_W'((int'(ptr_q) + k) % N_REQ);
            end
        end
        ptr_d = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
        gnt_d = N_REQ'(1) << win_id;
    end

    // Non-overlapping "1101" detector step for the bit now offered.
    always_comb begin
        eng_d = eng_q;
        match = 1'b0;
        case (eng_q)
            E_S0: eng_d = cur_bit ? E_S1 : E_S0;
            E_S1: eng_d = cur_bit ? E_S2 : E_S0;
            E_S2: eng_d = cur_bit ? E_S2 : E_S3;
            E_S3: begin
                eng_d = E_S0;
                match = cur_bit;
            end
            default: eng_d = E_S0;
        endcase
        hit_cnt_d = (match && (hit_cnt_q != {CNT_W{1'b1}})) ? hit_cnt_q + 1'b1 : hit_cnt_q;
    end

    // Controller: arbitration, frame streaming and the one-cycle report,
    // with every output registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            eng_q        <= E_S0;
            ptr_q        <= '0;
            g_q          <= '0;
            bit_cnt_q    <= '0;
            hit_cnt_q    <= '0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            hit_q        <= 1'b0;
            done_q       <= 1'b0;
            done_id_q    <= '0;
            done_cnt_q   <= '0;
            done_abort_q <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        state_q   <= ST_STREAM;
                        g_q       <= win_id;
                        ptr_q     <= ptr_d;
                        gnt_q     <= gnt_d;
                        eng_q     <= E_S0;
                        bit_cnt_q <= '0;
                        hit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (!cur_req) begin
                        // Request dropped: a bit offered this cycle is discarded.
                        state_q      <= ST_REPORT;
                        gnt_q        <= '0;
                        done_q       <= 1'b1;
                        done_id_q    <= g_q;
                        done_cnt_q   <= hit_cnt_q;
                        done_abort_q <= 1'b1;
                    end else if (cur_vld) begin
                        eng_q     <= eng_d;
                        hit_q     <= match;
                        hit_cnt_q <= hit_cnt_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            // Report includes a match on this final bit.
                            state_q      <= ST_REPORT;
                            gnt_q        <= '0;
                            done_q       <= 1'b1;
                            done_id_q    <= g_q;
                            done_cnt_q   <= hit_cnt_d;
                            done_abort_q <= 1'b0;
                        end
                    end
                end
                ST_REPORT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.busy       = busy_q;
    assign bus.hit        = hit_q;
    assign bus.done       = done_q;
    assign bus.done_id    = done_id_q;
    assign bus.done_cnt   = done_cnt_q;
    assign bus.done_abort = done_abort_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_seq_match_sched.sv
// Bench for seq_match_sched. It uses three instances: the default build,
// a FRAME_LEN=1 build for rotation and a CNT_W=2 / FRAME_LEN=32 build for
// saturation. Drivers push the expected frame result into exp_q. One
// monitor pops and compares it whenever any instance raises done.
module tb_seq_match_sched;

  typedef struct {
    int inst;
    int id;
    int cnt;
    int abort;
    int hits;
    int lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  logic [3:0] drv_req[3];
  logic [3:0] drv_vld[3];
  logic [3:0] drv_dat[3];
  logic [3:0] o_gnt[3];
  logic       o_busy[3];
  logic       o_hit[3];
  logic       o_done[3];
  logic [1:0] o_id[3];
  logic [3:0] o_cnt[3];
  logic       o_abort[3];
  logic [1:0] dbg_m, dbg_f, dbg_s;

  seq_match_sched_if #(.N_REQ(4), .CNT_W(4)) m_if ();
  seq_match_sched_if #(.N_REQ(4), .CNT_W(4)) f_if ();
  seq_match_sched_if #(.N_REQ(4), .CNT_W(2)) s_if ();

  seq_match_sched #(.N_REQ(4), .FRAME_LEN(16), .CNT_W(4)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(m_if.slave), .dbg_state_o(dbg_m));
  seq_match_sched #(.N_REQ(4), .FRAME_LEN(1), .CNT_W(4)) u_f1 (
    .clk(clk), .rst_n(rst_n), .bus(f_if.slave), .dbg_state_o(dbg_f));
  seq_match_sched #(.N_REQ(4), .FRAME_LEN(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(s_if.slave), .dbg_state_o(dbg_s));

  assign m_if.req = drv_req[0];
  assign m_if.bit_vld = drv_vld[0];
  assign m_if.bit_dat = drv_dat[0];
  assign f_if.req = drv_req[1];
  assign f_if.bit_vld = drv_vld[1];
  assign f_if.bit_dat = drv_dat[1];
  assign s_if.req = drv_req[2];
  assign s_if.bit_vld = drv_vld[2];
  assign s_if.bit_dat = drv_dat[2];

  assign o_gnt[0] = m_if.gnt;
  assign o_busy[0] = m_if.busy;
  assign o_hit[0] = m_if.hit;
  assign o_done[0] = m_if.done;
  assign o_id[0] = m_if.done_id;
  assign o_cnt[0] = m_if.done_cnt;
  assign o_abort[0] = m_if.done_abort;
  assign o_gnt[1] = f_if.gnt;
  assign o_busy[1] = f_if.busy;
  assign o_hit[1] = f_if.hit;
  assign o_done[1] = f_if.done;
  assign o_id[1] = f_if.done_id;
  assign o_cnt[1] = f_if.done_cnt;
  assign o_abort[1] = f_if.done_abort;
  assign o_gnt[2] = s_if.gnt;
  assign o_busy[2] = s_if.busy;
  assign o_hit[2] = s_if.hit;
  assign o_done[2] = s_if.done;
  assign o_id[2] = s_if.done_id;
  assign o_cnt[2] = {2'b00, s_if.done_cnt};
  assign o_abort[2] = s_if.done_abort;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor
  int         hit_acc[3];
  int         rise_cyc[3];
  int         last_done[3];
  logic [3:0] prev_gnt[3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      hit_acc[k] = 0;
      rise_cyc[k] = 0;
      last_done[k] = -1;
      prev_gnt[k] = '0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        hit_acc[k] = 0;
        prev_gnt[k] = '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (o_gnt[k] != 4'd0 && prev_gnt[k] == 4'd0) begin
          rise_cyc[k] = cyc;
          chk("gnt_onehot", $onehot(o_gnt[k]), o_gnt[k], 1);
          if (last_done[k] >= 0) begin
            if (k == 1) chk("idle_gap", (cyc - last_done[k]) == 2, cyc - last_done[k], 2);
            else chk("idle_gap_min", (cyc - last_done[k]) >= 2, cyc - last_done[k], 2);
          end
        end
        if (o_hit[k]) hit_acc[k]++;
        if (o_done[k]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1'b0, k, -1);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("done_inst", e.inst == k, k, e.inst);
            chk("done_id", int'(o_id[k]) == e.id, o_id[k], e.id);
            chk("done_cnt", int'(o_cnt[k]) == e.cnt, o_cnt[k], e.cnt);
            chk("done_abort", int'(o_abort[k]) == e.abort, o_abort[k], e.abort);
            chk("hit_pulses", hit_acc[k] == e.hits, hit_acc[k], e.hits);
            chk("done_latency", (cyc - rise_cyc[k]) == e.lat, cyc - rise_cyc[k], e.lat);
            chk("busy_in_report", o_busy[k] == 1'b1, o_busy[k], 1);
            chk("gnt_off_in_report", o_gnt[k] == 4'd0, o_gnt[k], 0);
          end
          hit_acc[k] = 0;
          last_done[k] = cyc;
        end
        prev_gnt[k] = o_gnt[k];
      end
    end
  end

  // Driver: one frame on channel ch of instance inst, bits sent MSB first.
  // drop_after>0 lowers req while offering bit number drop_after (0-based).
  task automatic frame(input int inst, input int ch, input logic [63:0] bits, input int n,
                       input bit gap_en, input int drop_after, input int exp_cnt,
                       input int exp_hits);
    int   i;
    int   gaps;
    int   waited;
    exp_t e;
    drv_req[inst][ch] = 1'b1;
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (o_gnt[inst][ch] !== 1'b1 && waited < 20);
    chk("grant_wait", o_gnt[inst][ch] === 1'b1, waited, 1);
    if (o_gnt[inst][ch] !== 1'b1) begin
      drv_req[inst][ch] = 1'b0;
      return;
    end
    i = 0;
    gaps = 0;
    while (i < n) begin
      if (gap_en && $urandom_range(0, 2) == 0) begin
        drv_vld[inst][ch] = 1'b0;
        gaps++;
      end else begin
        drv_vld[inst][ch] = 1'b1;
        drv_dat[inst][ch] = bits[n-1-i];
        if (drop_after != 0 && i == drop_after) drv_req[inst][ch] = 1'b0;
        i++;
      end
      @(posedge clk);
      #1;
      if (drop_after != 0 && i > drop_after) break;
    end
    drv_vld[inst][ch] = 1'b0;
    drv_dat[inst][ch] = 1'b0;
    drv_req[inst][ch] = 1'b0;
    e.inst = inst;
    e.id = ch;
    e.cnt = exp_cnt;
    e.abort = (drop_after != 0) ? 1 : 0;
    e.hits = exp_hits;
    e.lat = i + gaps;
    exp_q.push_back(e);
  endtask

  task automatic chk_main_zero(input string tag);
    chk({tag, "_gnt"}, m_if.gnt == 4'd0, m_if.gnt, 0);
    chk({tag, "_busy"}, m_if.busy == 1'b0, m_if.busy, 0);
    chk({tag, "_hit"}, m_if.hit == 1'b0, m_if.hit, 0);
    chk({tag, "_done"}, m_if.done == 1'b0, m_if.done, 0);
    chk({tag, "_done_id"}, m_if.done_id == 2'd0, m_if.done_id, 0);
    chk({tag, "_done_cnt"}, m_if.done_cnt == 4'd0, m_if.done_cnt, 0);
    chk({tag, "_done_abort"}, m_if.done_abort == 1'b0, m_if.done_abort, 0);
    chk({tag, "_state"}, dbg_m == 2'd0, dbg_m, 0);
  endtask

  // Stimulus
  initial begin
    int   n;
    int   waited;
    logic [6:0] part;
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      drv_req[k] = '0;
      drv_vld[k] = '0;
      drv_dat[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_main_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ch0, 1101 x4 back to back: 4 hits, last on the final bit, 16-cycle frame
    frame(0, 0, 64'hDDDD, 16, 1'b0, 0, 4, 4);
    repeat (2) @(posedge clk);
    #1;
    // ch1, 1101101 then 111101001 with idle-valid gaps: matches at bits 4 and 13
    frame(0, 1, 64'hDBE9, 16, 1'b1, 0, 2, 2);
    repeat (2) @(posedge clk);
    #1;
    // ch2 abort: 11011 then req drop with a 1 offered -> discarded, 1 match
    frame(0, 2, 64'b110111, 6, 1'b0, 5, 1, 1);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-frame after 7 bits on ch1: outputs clear, no done
    part = 7'b1101110;
    drv_req[0][1] = 1'b1;
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (m_if.gnt[1] !== 1'b1 && waited < 20);
    chk("grant_wait_rst", m_if.gnt[1] === 1'b1, waited, 1);
    for (int i = 0; i < 7; i++) begin
      drv_vld[0][1] = 1'b1;
      drv_dat[0][1] = part[6-i];
      @(posedge clk);
      #1;
    end
    drv_vld[0][1] = 1'b0;
    chk("busy_before_rst", m_if.busy == 1'b1, m_if.busy, 1);
    rst_n = 1'b0;
    #1;
    chk_main_zero("midrst");
    drv_req[0] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame(0, 3, 64'hDDDD, 16, 1'b0, 0, 4, 4);
    repeat (3) @(posedge clk);
    #1;

    // FRAME_LEN=1 build: all requests high, ids rotate 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      e.inst = 1;
      e.id = k % 4;
      e.cnt = 0;
      e.abort = 0;
      e.hits = 0;
      e.lat = 1;
      exp_q.push_back(e);
    end
    drv_vld[1] = 4'hF;
    drv_dat[1] = 4'h0;
    drv_req[1] = 4'hF;
    n = 0;
    waited = 0;
    while (n < 5 && waited < 100) begin
      @(negedge clk);
      waited++;
      if (f_if.done) n++;
    end
    drv_req[1] = 4'h0;
    drv_vld[1] = 4'h0;
    chk("f1_frames", n == 5, n, 5);
    repeat (4) @(posedge clk);
    #1;

    // Saturation build: 1101 x8 gives 8 hits, count saturates at 3
    frame(2, 0, 64'hDDDDDDDD, 32, 1'b0, 0, 3, 8);

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    chk("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
